// File: rtl/control_sequencer_if.sv
// Control-sequencer <-> data_path signal bundle.
// The master modport is the sequencer: it reads run, mem_ready and the
// fed-back IR and drives every bus-drive, load and ALU-select strobe.
// The slave modport is the data_path (or a bench standing in for it).
interface control_sequencer_if;
   // Inputs to the sequencer
   logic        run;
   logic        mem_ready;
   logic [31:0] ir;

   // Bus drive strobes
   logic        PCout;
   logic        Zlowout;
   logic        MDRout;

   // Load / control strobes
   logic        MARin;
   logic        Zin;
   logic        PCin;
   logic        MDRin;
   logic        IRin;
   logic        Yin;
   logic        IncPC;
   logic        Read;

   // GPR selects and ALU function
   logic [15:0] reg_out;
   logic [15:0] reg_in;
   logic [3:0]  alu_op;

   // Status
   logic        halted;
   logic        illegal;

   modport master (
      input  run, mem_ready, ir,
      output PCout, Zlowout, MDRout,
      output MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
      output reg_out, reg_in, alu_op,
      output halted, illegal
   );

   modport slave (
      output run, mem_ready, ir,
      input  PCout, Zlowout, MDRout,
      input  MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
      input  reg_out, reg_in, alu_op,
      input  halted, illegal
   );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired control unit for data_path.
// Fetch: T0 (PC->MAR, PC+1->Z), T1 (Z->PC, start read), T1W (wait for
// slow memory), T2 (MDR->IR). Execute for three-operand ALU ops:
// T3 (Rb->Y), T4 (Rc, ALU->Z), T5 (Z->Ra). Halt and undefined opcodes
// park the unit in HALT until clear. All strobes are a pure decode of
// the state register and the IR, so clear zeroes them without a clock.
module control_sequencer #(
   parameter int PC_RESET_HOLD = 1   // cycles in RESET_ST before fetch (1..15)
) (
   input  logic                    clock,
   input  logic                    clear,
   control_sequencer_if.master     bus
);

   typedef enum logic [3:0] {
      RESET_ST,
      T0,
      T1,
      T1W,
      T2,
      T3,
      T4,
      T5,
      HALT
   } state_t;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_NONE = 4'b0000;
   localparam logic [3:0] ALU_ADD  = 4'b0001;
   localparam logic [3:0] ALU_SUB  = 4'b0010;
   localparam logic [3:0] ALU_AND  = 4'b0011;
   localparam logic [3:0] ALU_OR   = 4'b0100;

   // Last count value spent in RESET_ST; the counter saturates here.
   localparam logic [3:0] HOLD_LAST = 4'(PC_RESET_HOLD - 1);

   state_t     state_q, state_d;
   logic [3:0] hold_q,  hold_d;
   logic       illegal_q, illegal_d;

   // IR fields
   logic [4:0] opcode;
   logic [3:0] ra, rb, rc;
   logic [3:0] alu_sel;
   logic       unused_ir_bits;

   assign opcode = bus.ir[31:27];
   assign ra     = bus.ir[26:23];
   assign rb     = bus.ir[22:19];
   assign rc     = bus.ir[18:15];

   // Low IR bits carry immediates/unused fields that this unit ignores.
   assign unused_ir_bits = ^bus.ir[14:0];

   function automatic logic [15:0] onehot16(input logic [3:0] idx);
      return 16'd1 << idx;
   endfunction

   // Opcode to ALU function; ALU_NONE marks anything that is not a
   // three-operand ALU instruction.
   always_comb begin
      alu_sel = ALU_NONE;
      case (opcode)
         OP_ADD:  alu_sel = ALU_ADD;
         OP_SUB:  alu_sel = ALU_SUB;
         OP_AND:  alu_sel = ALU_AND;
         OP_OR:   alu_sel = ALU_OR;
         default: alu_sel = ALU_NONE;
      endcase
   end

   // State, reset-hold counter and sticky illegal flag.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q   <= RESET_ST;
         hold_q    <= 4'd0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic and strobe decode.
   always_comb begin
      state_d     = state_q;
      hold_d      = 4'd0;          // counter is only live inside RESET_ST
      illegal_d   = illegal_q;

      bus.PCout   = 1'b0;
      bus.Zlowout = 1'b0;
      bus.MDRout  = 1'b0;
      bus.MARin   = 1'b0;
      bus.Zin     = 1'b0;
      bus.PCin    = 1'b0;
      bus.MDRin   = 1'b0;
      bus.IRin    = 1'b0;
      bus.Yin     = 1'b0;
      bus.IncPC   = 1'b0;
      bus.Read    = 1'b0;
      bus.reg_out = 16'd0;
      bus.reg_in  = 16'd0;
      bus.alu_op  = ALU_NONE;
      bus.halted  = (state_q == HALT);
      bus.illegal = illegal_q;

      case (state_q)
         RESET_ST: begin
            hold_d = hold_q;
            if (hold_q >= HOLD_LAST) begin
               if (bus.run) state_d = T0;
            end else begin
               hold_d = hold_q + 4'd1;
            end
         end
         T0: begin
            bus.PCout = 1'b1;
            bus.MARin = 1'b1;
            bus.IncPC = 1'b1;
            bus.Zin   = 1'b1;
            state_d   = T1;
         end
         T1: begin
            bus.Zlowout = 1'b1;
            bus.PCin    = 1'b1;
            bus.Read    = 1'b1;
            bus.MDRin   = 1'b1;
            state_d     = bus.mem_ready ? T2 : T1W;
         end
         T1W: begin
            // PC was already reloaded in T1; only keep the read going.
            bus.Read  = 1'b1;
            bus.MDRin = 1'b1;
            state_d   = bus.mem_ready ? T2 : T1W;
         end
         T2: begin
            bus.MDRout = 1'b1;
            bus.IRin   = 1'b1;
            state_d    = T3;
         end
         T3: begin
            if (alu_sel != ALU_NONE) begin
               bus.Yin     = 1'b1;
               bus.reg_out = onehot16(rb);
               state_d     = T4;
            end else begin
               state_d = HALT;
               if (opcode != OP_HALT) illegal_d = 1'b1;
            end
         end
         T4: begin
            bus.reg_out = onehot16(rc);
            bus.Zin     = 1'b1;
            bus.alu_op  = alu_sel;
            state_d     = T5;
         end
         T5: begin
            bus.Zlowout = 1'b1;
            bus.reg_in  = onehot16(ra);
            state_d     = bus.run ? T0 : RESET_ST;
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = RESET_ST;
         end
      endcase
   end

endmodule
